// File: rtl/mod_n_counter_if.sv
// Control and status bundle for one mod_n_counter stage.
// master drives the controls and observes status; slave is the counter itself.
interface mod_n_counter_if #(
    parameter int WIDTH = 4
);
    // There is no valid/ready pairing: every control is sampled on each rising
    // edge, with priority clear > load > en. The status signals count, done and
    // load_err are registered. tc is combinational and valid in the same cycle.
    logic             en;
    logic             up;
    logic             one_shot;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
    logic             load_err;

    modport master (
        output en, up, one_shot, clear, load, load_val,
        input  count, tc, done, load_err
    );

    modport slave (
        input  en, up, one_shot, clear, load, load_val,
        output count, tc, done, load_err
    );
endinterface

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with clear, range-checked load,
// cascadable terminal count and a sticky one-shot completion flag.
module mod_n_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    mod_n_counter_if.slave   bus
);
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_n_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic             done_q;
    logic             load_err_q;

    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] step_val;
    logic             at_term;
    logic             load_ok;

    // One extra bit lets MODULUS = 2**WIDTH accept every load value.
    assign load_ok  = ({1'b0, bus.load_val} < MOD_EXT);
    assign term_val = bus.up ? LAST : '0;
    assign wrap_val = bus.up ? '0 : LAST;
    assign step_val = bus.up ? (count_q + ONE) : (count_q - ONE);
    assign at_term  = (count_q == term_val);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= 1'b0;
            if (bus.clear) begin
                count_q <= '0;
                done_q  <= 1'b0;
            end else if (bus.load) begin
                if (load_ok) begin
                    count_q <= bus.load_val;
                    done_q  <= 1'b0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (bus.en && !done_q) begin
                // At the terminal value a one-shot run parks; otherwise wrap.
                if (at_term) begin
                    if (bus.one_shot) begin
                        done_q <= 1'b1;
                    end else begin
                        count_q <= wrap_val;
                    end
                end else begin
                    count_q <= step_val;
                end
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;
    assign bus.tc       = bus.en & ~bus.clear & ~bus.load & ~done_q & at_term;
endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: a single decade stage, a two-stage BCD cascade and a
// full-range 3-bit mod-8 stage, checked against an expected-value queue.
module tb_mod_n_counter;
    logic clk;
    logic reset_n;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    mod_n_counter_if #(.WIDTH(4)) a_if ();
    mod_n_counter_if #(.WIDTH(4)) l_if ();
    mod_n_counter_if #(.WIDTH(4)) h_if ();
    mod_n_counter_if #(.WIDTH(3)) c_if ();

    mod_n_counter #(.WIDTH(4), .MODULUS(10)) dut_a  (.clk(clk), .reset_n(reset_n), .bus(a_if));
    mod_n_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (.clk(clk), .reset_n(reset_n), .bus(l_if));
    mod_n_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (.clk(clk), .reset_n(reset_n), .bus(h_if));
    mod_n_counter #(.WIDTH(3), .MODULUS(8))  dut_c  (.clk(clk), .reset_n(reset_n), .bus(c_if));

    assign h_if.en = l_if.tc;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the single decade stage, entered and left at posedge+1.
    task automatic drive_a(input string tag, input logic en, input logic up, input logic os,
                           input logic cl, input logic ld, input logic [3:0] lv,
                           input logic e_tc, input logic [3:0] e_cnt,
                           input logic e_done, input logic e_err);
        logic [15:0] got;
        a_if.en = en; a_if.up = up; a_if.one_shot = os;
        a_if.clear = cl; a_if.load = ld; a_if.load_val = lv;
        #1;
        check({tag, "_tc"}, 32'(a_if.tc), 32'(e_tc));
        exp_q.push_back({10'd0, e_cnt, e_done, e_err});
        @(posedge clk); #1;
        got = {10'd0, a_if.count, a_if.done, a_if.load_err};
        check(tag, 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic drive_c(input string tag, input logic en, input logic ld, input logic [2:0] lv,
                           input logic e_tc, input logic [2:0] e_cnt, input logic e_err);
        logic [15:0] got;
        c_if.en = en; c_if.up = 1'b1; c_if.one_shot = 1'b0;
        c_if.clear = 1'b0; c_if.load = ld; c_if.load_val = lv;
        #1;
        check({tag, "_tc"}, 32'(c_if.tc), 32'(e_tc));
        exp_q.push_back({12'd0, e_cnt, e_err});
        @(posedge clk); #1;
        got = {12'd0, c_if.count, c_if.load_err};
        check(tag, 32'(got), 32'(exp_q.pop_front()));
    endtask

    initial begin
        logic [15:0] got;
        reset_n = 1'b0;
        a_if.en = 0; a_if.up = 1; a_if.one_shot = 0; a_if.clear = 0; a_if.load = 0; a_if.load_val = '0;
        l_if.en = 0; l_if.up = 1; l_if.one_shot = 0; l_if.clear = 0; l_if.load = 0; l_if.load_val = '0;
        h_if.up = 1; h_if.one_shot = 0; h_if.clear = 0; h_if.load = 0; h_if.load_val = '0;
        c_if.en = 0; c_if.up = 1; c_if.one_shot = 0; c_if.clear = 0; c_if.load = 0; c_if.load_val = '0;

        // reset state
        #12;
        check("rst_count", 32'(a_if.count), 0);
        check("rst_done", 32'(a_if.done), 0);
        check("rst_err", 32'(a_if.load_err), 0);
        check("rst_c_count", 32'(c_if.count), 0);
        a_if.en = 1; a_if.up = 0;
        #1 check("rst_tc_down", 32'(a_if.tc), 1);
        a_if.en = 0; a_if.up = 1;
        #1 check("rst_tc_idle", 32'(a_if.tc), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // free-running up, 25 cycles
        for (int i = 0; i < 25; i++)
            drive_a("run_up", 1, 1, 0, 0, 0, 4'd0, (i % 10) == 9, 4'((i + 1) % 10), 0, 0);

        // down wrap and direction change
        drive_a("clr",   0, 1, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0);
        drive_a("dn_0",  1, 0, 0, 0, 0, 4'd0, 1, 4'd9, 0, 0);
        drive_a("dn_9",  1, 0, 0, 0, 0, 4'd0, 0, 4'd8, 0, 0);
        drive_a("dn_8",  1, 0, 0, 0, 0, 4'd0, 0, 4'd7, 0, 0);
        drive_a("up_7",  1, 1, 0, 0, 0, 4'd0, 0, 4'd8, 0, 0);
        drive_a("up_8",  1, 1, 0, 0, 0, 4'd0, 0, 4'd9, 0, 0);
        drive_a("up_9",  1, 1, 0, 0, 0, 4'd0, 1, 4'd0, 0, 0);

        // load legality
        drive_a("ld6",   1, 1, 0, 0, 1, 4'd6,  0, 4'd6, 0, 0);
        drive_a("ld12",  1, 1, 0, 0, 1, 4'd12, 0, 4'd6, 0, 1);
        drive_a("hold",  0, 1, 0, 0, 0, 4'd0,  0, 4'd6, 0, 0);
        drive_a("ld10",  0, 1, 0, 0, 1, 4'd10, 0, 4'd6, 0, 1);
        drive_a("ld9",   0, 1, 0, 0, 1, 4'd9,  0, 4'd9, 0, 0);
        drive_a("ldclr", 1, 1, 0, 1, 1, 4'd3,  0, 4'd0, 0, 0);

        // one-shot
        drive_a("os_ld7",   0, 1, 1, 0, 1, 4'd7,  0, 4'd7, 0, 0);
        drive_a("os_7",     1, 1, 1, 0, 0, 4'd0,  0, 4'd8, 0, 0);
        drive_a("os_8",     1, 1, 1, 0, 0, 4'd0,  0, 4'd9, 0, 0);
        drive_a("os_hit",   1, 1, 1, 0, 0, 4'd0,  1, 4'd9, 1, 0);
        drive_a("os_park",  1, 1, 1, 0, 0, 4'd0,  0, 4'd9, 1, 0);
        drive_a("os_en0",   0, 1, 1, 0, 0, 4'd0,  0, 4'd9, 1, 0);
        drive_a("os_badld", 0, 1, 1, 0, 1, 4'd12, 0, 4'd9, 1, 1);
        drive_a("os_ld3",   0, 1, 1, 0, 1, 4'd3,  0, 4'd3, 0, 0);
        for (int v = 3; v < 9; v++)
            drive_a("os_run", 1, 1, 1, 0, 0, 4'd0, 0, 4'(v + 1), 0, 0);
        drive_a("os_hit2",  1, 1, 1, 0, 0, 4'd0,  1, 4'd9, 1, 0);
        a_if.en = 0;

        // cascade: BCD pair over 37 enabled cycles
        for (int i = 0; i < 37; i++) begin
            l_if.en = 1;
            #1 check("cas_tc", 32'(l_if.tc), 32'((i % 10) == 9));
            exp_q.push_back(16'({4'((i + 1) / 10), 4'((i + 1) % 10)}));
            @(posedge clk); #1;
            got = 16'({h_if.count, l_if.count});
            check("cas_pair", 32'(got), 32'(exp_q.pop_front()));
        end
        l_if.en = 0;
        check("cas_hi", 32'(h_if.count), 3);
        check("cas_lo", 32'(l_if.count), 7);
        check("a_parked", 32'(a_if.done), 1);

        // asynchronous reset pulse mid-cycle
        #2 reset_n = 1'b0;
        #1;
        check("arst_lo", 32'(l_if.count), 0);
        check("arst_hi", 32'(h_if.count), 0);
        check("arst_a_count", 32'(a_if.count), 0);
        check("arst_a_done", 32'(a_if.done), 0);
        check("arst_a_err", 32'(a_if.load_err), 0);
        reset_n = 1'b1;
        drive_a("post_rst", 0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0);
        check("post_rst_lo", 32'(l_if.count), 0);
        check("post_rst_hi_done", 32'(h_if.done | h_if.load_err | l_if.load_err), 0);

        // full-range modulus 8 on 3 bits
        for (int i = 0; i < 9; i++)
            drive_c("c_run", 1, 0, 3'd0, (i % 8) == 7, 3'((i + 1) % 8), 0);
        for (int v = 7; v >= 0; v--)
            drive_c("c_ld", 1, 1, 3'(v), 0, 3'(v), 0);

        check("q_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Parametrised modulo-N up/down counter, the general successor to the fixed mod-8 counter. It adds enable, direction, synchronous clear, parallel load with range checking, a terminal-count output for cascading, and a one-shot mode. It is a leaf block for timers, prescalers and digit counters, such as BCD stages that are chained through `tc`.

## Interface

- `WIDTH`, 4: counter width in bits.
- `MODULUS`, 10: count range is 0 to MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH; an illegal value is a static error raised by an elaboration-time check.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: count enable.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `one_shot` input 1: 1 = halt at the terminal value; 0 = free-running wrap.
- `clear` input 1: synchronous clear to 0.
- `load` input 1: synchronous parallel load.
- `load_val` input WIDTH: value to load.
- `count` output WIDTH: registered count.
- `tc` output 1: combinational terminal-count / carry for cascading.
- `done` output 1: registered sticky flag, set when a one-shot run completes.
- `load_err` output 1: registered one-cycle pulse flagging a rejected load.

## Operation

- Terminal value T = MODULUS-1 when `up`=1, and 0 when `up`=0.
- Per-edge priority, highest first: `clear`, then `load`, then `en`, then hold.
- `clear`=1:
  - `count` ← 0, `done` ← 0, `load_err` ← 0.
  - `load` and `en` are ignored in that cycle.
- `load`=1 with `clear`=0:
  - If `load_val` < MODULUS: `count` ← `load_val`, `done` ← 0.
  - Otherwise: `count` unchanged, `done` unchanged, `load_err` ← 1 for one cycle.
  - `en` is ignored in a load cycle.
- `en`=1 with no clear or load:
  - If `count` ≠ T: `count` moves one step toward T (+1 if `up`, −1 if not).
  - If `count` = T and `one_shot`=0: wrap. Up mode goes MODULUS-1 → 0; down mode goes 0 → MODULUS-1.
  - If `count` = T and `one_shot`=1: `count` holds at T and `done` ← 1.
  - Once `done`=1, `count` holds regardless of `en`. Only `clear`, a legal `load`, or reset releases it.
- `en`=0: `count` holds.
- `load_err` is 0 in every cycle that does not follow a rejected load.
- `up` may change in any cycle; it takes effect at the next edge. Decrementing from 0 in free-running mode wraps to MODULUS-1.
- `tc` = `en` & ~`clear` & ~`load` & ~`done` & (`count` = T).
  - It is a single combinational term, so a downstream counter can use it directly as its `en`.
- Arithmetic is WIDTH bits and unsigned. `count` never holds a value ≥ MODULUS, including when MODULUS = 2^WIDTH, where the wrap coincides with natural overflow.

## Timing

- Reset (`reset_n`=0), applied asynchronously:
  - `count`=0, `done`=0, `load_err`=0.
  - `tc` evaluates from inputs (0 unless `en`=1 and `up`=0 at `count`=0).
- Reset release is synchronous to `clk`: the first update happens on the first rising edge after `reset_n` is sampled high.
- Reset mid-run, including mid one-shot: all state returns to reset values immediately, and no `done` or `load_err` pulse is produced.
- Latency:
  - `count` updates 1 cycle after `en`, `load` or `clear` is sampled.
  - `load_err` is asserted in the cycle after the rejected load, for exactly one cycle.
  - `done` is asserted in the cycle after the terminal-hit edge.
- `tc` has zero latency: it is valid in the same cycle as the `count` and `en` that cause it.
- Cascaded stages therefore advance on the same edge as the wrapping low stage.
- Throughput: one step per clock when `en` is held high.

## Test plan

- Reset and free-run up: MODULUS=10, `en`=1, `up`=1 from reset for 25 cycles.
  - `count` sequence 0..9,0..9,0..4.
  - `tc`=1 exactly when `count`=9.
  - `done` stays 0.
- Down wrap and direction change: `up`=0 from `count`=0.
  - `count` goes to 9, 8, 7.
  - Switching `up`=1 at 7 gives 8, 9, 0.
  - `tc` is high at 0 while counting down and at 9 while counting up.
- Load legality: MODULUS=10, WIDTH=4, `load`=1.
  - `load_val`=6 gives `count`=6 next cycle with `load_err`=0.
  - `load_val`=12 leaves `count` unchanged and gives `load_err`=1 for exactly one cycle.
  - `load` together with `clear` gives `count`=0.
- One-shot: `one_shot`=1, `up`=1, load 7.
  - `count` goes 8, 9, then holds at 9.
  - `done`=1 from the cycle after the hit; `tc`=0 while `done`=1.
  - `load` of 3 releases it: `done`=0 and counting resumes at 3.
- Cascade and reset: two instances (MODULUS=10), with the high stage's `en` driven by the low stage's `tc`.
  - After 37 enabled cycles from reset, the pair reads 3,7.
  - Pulsing `reset_n` low mid-cycle zeros both stages immediately, with no `done`/`load_err` pulse.
- Full-range modulus: WIDTH=3, MODULUS=8.
  - Count sequence 0..7,0 when free-running.
  - `load_val`=7 is accepted; there is no `load_err` for any 3-bit value.
